// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - PS/2 mouse receiver: frame deserialiser and 3-byte packet assembler
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous mouse lines
//   packet_valid        one-cycle strobe; buttons/dx/dy/x_ovf/y_ovf updated
//   buttons, dx, dy     {middle,right,left}, signed 9-bit deltas (dy mouse-up positive)
//   x_ovf, y_ovf        overflow flags from the packet header
//   frame_error         one-cycle strobe on a dropped byte, bad header or timeout
//   cursor_x, cursor_y  screen-clamped cursor; built only with PS2_CURSOR_EN defined,
//                       otherwise tied to 0
module ps2_mouse_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       packet_valid,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       frame_error,
  output logic [9:0] cursor_x,
  output logic [9:0] cursor_y
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  state_t      state;
  logic [2:0]  bitcnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic        byte_ok;
  logic        byte_bad;

  logic [TW-1:0] tcnt;
  logic          active;
  logic          timeout;

  logic [1:0] idx;
  logic [2:0] hdr_btn;
  logic       hdr_xs, hdr_ys, hdr_xo, hdr_yo;
  logic [7:0] b1;
  logic       pkt_fire;

  // Synchronisers idle high so a reset never manufactures a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // A pending edge wins over an expiring timeout.
  assign active  = (state != IDLE) || (idx != 2'd0);
  assign timeout = active && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (fall || !active || timeout) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // Frame deserialiser; byte_ok/byte_bad are registered one-cycle results.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bitcnt   <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      byte_ok  <= 1'b0;
      byte_bad <= 1'b0;
    end else begin
      byte_ok  <= 1'b0;
      byte_bad <= 1'b0;
      if (timeout) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s2) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg  <= {data_s2, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s2;
            state   <= STOP;
          end
          STOP: begin
            if (data_s2 && (^{shreg, par_bit})) byte_ok <= 1'b1;
            else                                byte_bad <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign pkt_fire = byte_ok && (idx == 2'd2);

  // Packet assembly. shreg stays stable for the cycle after byte_ok because
  // the next frame cannot shift data in that soon.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx          <= 2'd0;
      hdr_btn      <= '0;
      hdr_xs       <= 1'b0;
      hdr_ys       <= 1'b0;
      hdr_xo       <= 1'b0;
      hdr_yo       <= 1'b0;
      b1           <= '0;
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
      buttons      <= '0;
      dx           <= '0;
      dy           <= '0;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
      if (timeout || byte_bad) begin
        idx         <= 2'd0;
        frame_error <= 1'b1;
      end else if (byte_ok) begin
        case (idx)
          2'd0: begin
            // Header must have bit3 set; otherwise stay at 0 to resync.
            if (shreg[3]) begin
              hdr_btn <= shreg[2:0];
              hdr_xs  <= shreg[4];
              hdr_ys  <= shreg[5];
              hdr_xo  <= shreg[6];
              hdr_yo  <= shreg[7];
              idx     <= 2'd1;
            end else begin
              frame_error <= 1'b1;
            end
          end
          2'd1: begin
            b1  <= shreg;
            idx <= 2'd2;
          end
          2'd2: begin
            buttons      <= hdr_btn;
            dx           <= {hdr_xs, b1};
            dy           <= {hdr_ys, shreg};
            x_ovf        <= hdr_xo;
            y_ovf        <= hdr_yo;
            packet_valid <= 1'b1;
            idx          <= 2'd0;
          end
          default: idx <= 2'd0;
        endcase
      end
    end
  end

`ifdef PS2_CURSOR_EN
  localparam logic signed [11:0] X_LIM = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM = 12'(Y_MAX);

  logic signed [11:0] dx_ext, dy_ext, x_sum, y_sum;
  logic [9:0]         x_next, y_next;

  always_comb begin
    dx_ext = {{4{hdr_xs}}, b1};
    dy_ext = {{4{hdr_ys}}, shreg};
    x_sum  = $signed({2'b00, cursor_x}) + dx_ext;
    // Screen Y grows downward while mouse dy is up-positive.
    y_sum  = $signed({2'b00, cursor_y}) - dy_ext;
    if (x_sum < 0)          x_next = '0;
    else if (x_sum > X_LIM) x_next = 10'(X_MAX);
    else                    x_next = x_sum[9:0];
    if (y_sum < 0)          y_next = '0;
    else if (y_sum > Y_LIM) y_next = 10'(Y_MAX);
    else                    y_next = y_sum[9:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cursor_x <= 10'(X_MAX / 2);
      cursor_y <= 10'(Y_MAX / 2);
    end else if (pkt_fire) begin
      if (!hdr_xo) cursor_x <= x_next;
      if (!hdr_yo) cursor_y <= y_next;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = pkt_fire;
  // Masked to zero; the reference keeps the screen bounds in use.
  assign cursor_x = 10'(X_MAX) & 10'd0;
  assign cursor_y = 10'(Y_MAX) & 10'd0;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb/tb_ps2_mouse_rx.sv - self-checking bench for ps2_mouse_rx
module tb_ps2_mouse_rx;

  localparam int TMO   = 2000;
  localparam int XMAX  = 639;
  localparam int YMAX  = 479;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       packet_valid, x_ovf, y_ovf, frame_error;
  logic [2:0] buttons;
  logic [8:0] dx, dy;
  logic [9:0] cursor_x, cursor_y;

  ps2_mouse_rx #(.TIMEOUT_CYCLES(TMO), .X_MAX(XMAX), .Y_MAX(YMAX)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .packet_valid(packet_valid), .buttons(buttons), .dx(dx), .dy(dy),
    .x_ovf(x_ovf), .y_ovf(y_ovf), .frame_error(frame_error),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] b;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       xo;
    logic       yo;
    int         cx;
    int         cy;
  } pkt_t;

  pkt_t       expq[$];
  pkt_t       cur;
  int         vectors = 0;
  int         fails = 0;
  int         exp_err = 0;
  int         dut_err = 0;
  int         stop_cyc = 0;
  int         m_idx;
  logic [7:0] m_b0, m_b1;
  int         m_cx, m_cy;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int s9(logic [8:0] v);
    return v[8] ? int'(v) - 512 : int'(v);
  endfunction

  function automatic int sat(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_idx = 0;
`ifdef PS2_CURSOR_EN
    m_cx = XMAX / 2;
    m_cy = YMAX / 2;
`else
    m_cx = 0;
    m_cy = 0;
`endif
    cur = '{b: 3'd0, dx: 9'd0, dy: 9'd0, xo: 1'b0, yo: 1'b0, cx: m_cx, cy: m_cy};
    expq.delete();
  endtask

  // Packet rules from the protocol: drop bad frames, resync on bad header,
  // emit a packet on every third accepted byte.
  task automatic model_byte(logic [7:0] v, bit good);
    pkt_t p;
    if (!good) begin
      exp_err++;
      m_idx = 0;
    end else if (m_idx == 0) begin
      if (v[3]) begin
        m_b0 = v;
        m_idx = 1;
      end else begin
        exp_err++;
      end
    end else if (m_idx == 1) begin
      m_b1 = v;
      m_idx = 2;
    end else begin
      p.b  = m_b0[2:0];
      p.dx = {m_b0[4], m_b1};
      p.dy = {m_b0[5], v};
      p.xo = m_b0[6];
      p.yo = m_b0[7];
`ifdef PS2_CURSOR_EN
      if (!p.xo) m_cx = sat(m_cx + s9(p.dx), XMAX);
      if (!p.yo) m_cy = sat(m_cy - s9(p.dy), YMAX);
`endif
      p.cx = m_cx;
      p.cy = m_cy;
      expq.push_back(p);
      m_idx = 0;
    end
  endtask

  always @(negedge clk) begin
    if (frame_error === 1'b1) dut_err++;
    if (packet_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_packet", 32'd1, 32'd0);
      end else begin
        cur = expq.pop_front();
        chk("latency", cyc - stop_cyc, 32'd4);
      end
    end
    chk("buttons", buttons, cur.b);
    chk("dx", dx, cur.dx);
    chk("dy", dy, cur.dy);
    chk("x_ovf", x_ovf, cur.xo);
    chk("y_ovf", y_ovf, cur.yo);
    chk("cursor_x", cursor_x, cur.cx);
    chk("cursor_y", cursor_y, cur.cy);
  end

  task automatic wait_clk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(logic [7:0] v, bit bad_par, int nbits);
    logic [10:0] bits;
    logic        par;
    par  = (~^v) ^ bad_par;
    bits = {1'b1, par, v, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(10);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_clk(20);
      ps2_clk = 1'b1;
      wait_clk(10);
    end
  endtask

  task automatic send_byte(logic [7:0] v, bit good = 1'b1);
    model_byte(v, good);
    send_bits(v, !good, 11);
    ps2_data = 1'b1;
    wait_clk(60);
  endtask

  task automatic check_totals(string name);
    wait_clk(20);
    chk({name, "_errors"}, dut_err, exp_err);
    chk({name, "_pending"}, expq.size(), 32'd0);
  endtask

  int base_err;

  initial begin
    model_reset();
    wait_clk(3);
    chk("rst_packet_valid", packet_valid, 32'd0);
    chk("rst_frame_error", frame_error, 32'd0);
    chk("rst_buttons", buttons, 32'd0);
    chk("rst_dx", dx, 32'd0);
    chk("rst_dy", dy, 32'd0);
    reset = 1'b0;
    wait_clk(5);

    // Basic packet
    send_byte(8'h29); send_byte(8'h05); send_byte(8'hFB);
    check_totals("basic");
    chk("lit_buttons", buttons, 32'h1);
    chk("lit_dx", dx, 32'h005);
    chk("lit_dy", dy, 32'h1FB);
    chk("lit_ovf", {x_ovf, y_ovf}, 32'h0);
    chk("lit_err", dut_err, 32'd0);
`ifdef PS2_CURSOR_EN
    chk("lit_cx", cursor_x, 32'd324);
    chk("lit_cy", cursor_y, 32'd244);
`endif

    // Bad parity mid-packet, then a clean packet
    send_byte(8'h08); send_byte(8'h05, 1'b0);
    send_byte(8'h09); send_byte(8'h03); send_byte(8'hFE);
    check_totals("parity");
    chk("lit_par_dx", dx, 32'h003);
    chk("lit_par_dy", dy, 32'h0FE);
    chk("lit_par_err", dut_err, 32'd1);

    // Header without bit3 is discarded
    base_err = dut_err;
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h01); send_byte(8'h02);
    check_totals("resync");
    chk("lit_rs_dx", dx, 32'h001);
    chk("lit_rs_dy", dy, 32'h002);
    chk("lit_rs_err", dut_err - base_err, 32'd1);

    // Timeout mid-packet
    base_err = dut_err;
    send_byte(8'h08); send_byte(8'h10);
    wait_clk(TMO + 10);
    exp_err++;
    m_idx = 0;
    check_totals("timeout");
    chk("lit_tmo_err", dut_err - base_err, 32'd1);
    send_byte(8'h0A); send_byte(8'h07); send_byte(8'h06);
    check_totals("after_timeout");
    chk("lit_tmo_btn", buttons, 32'h2);

    // Saturating left moves, then an X overflow packet
    for (int k = 0; k < 10; k++) begin
      send_byte(8'h18); send_byte(8'h80); send_byte(8'h00);
    end
    check_totals("sat");
    chk("lit_sat_dx", dx, 32'h180);
`ifdef PS2_CURSOR_EN
    chk("lit_sat_cx", cursor_x, 32'd0);
`endif
    send_byte(8'h48); send_byte(8'h10); send_byte(8'h00);
    check_totals("ovf");
    chk("lit_xovf", x_ovf, 32'd1);
`ifdef PS2_CURSOR_EN
    chk("lit_ovf_cx", cursor_x, 32'd0);
`endif

    // Reset after 5 bits of a frame
    send_bits(8'h08, 1'b0, 5);
    #2;
    model_reset();
    reset = 1'b1;
    #1;
    chk("mid_rst_pv", packet_valid, 32'd0);
    chk("mid_rst_xovf", x_ovf, 32'd0);
    chk("mid_rst_dx", dx, 32'd0);
    chk("mid_rst_btn", buttons, 32'd0);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(5);
    send_byte(8'h2C); send_byte(8'h01); send_byte(8'hFF);
    check_totals("after_reset");
    chk("lit_ar_dy", dy, 32'h1FF);

    // Long idle must not time out
    wait_clk(TMO + 100);
    check_totals("idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
- Receive-only PS/2 mouse front end. Samples the raw mouse clock/data lines, deserialises 11-bit device-to-host frames, and assembles standard 3-byte movement packets.
- Presents button state, signed 9-bit deltas and a one-cycle packet strobe to the IO controller, which drives the seven-segment display.
- Optionally maintains a screen-clamped cursor position for the VGA side.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles with no PS/2 falling edge mid-frame (or mid-packet) before the receiver aborts and resynchronises.
- X_MAX, 639: largest cursor X (only used with the optional feature).
- Y_MAX, 479: largest cursor Y (only used with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_clk  in  1  raw mouse clock, asynchronous
- ps2_data  in  1  raw mouse data, asynchronous
- packet_valid  out  1  one-cycle strobe; packet outputs updated
- buttons  out  3  {middle, right, left} from byte0[2:0]
- dx  out  9  two's complement X delta, {byte0[4], byte1}
- dy  out  9  two's complement Y delta, {byte0[5], byte2}, mouse-up positive
- x_ovf  out  1  byte0[6]
- y_ovf  out  1  byte0[7]
- frame_error  out  1  one-cycle strobe on a dropped byte or packet
- cursor_x  out  10  cursor X (optional feature only)
- cursor_y  out  10  cursor Y (optional feature only)

Behaviour:
- Clocking and reset: single clk domain. Reset is asynchronous, active-high; all registers clear immediately on assertion.
- Reset values: packet_valid=0, frame_error=0, buttons=0, dx=0, dy=0, x_ovf=0, y_ovf=0, bit counter=0, byte index=0, timeout counter=0. Synchronisers reset to 1 (idle high).
- Input conditioning: 2-FF synchroniser on ps2_clk and ps2_data, then a previous-value register. fall = prev & ~sync_clk. Data is sampled as sync_data on the fall cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 (start bit), go to DATA with bitcnt=0. On fall with data=1, stay in IDLE, no error.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: check stop=1 and odd parity (XOR of 8 data bits and parity = 1).
    - Pass: byte accepted, go to IDLE.
    - Fail: byte dropped, frame_error pulses, byte index cleared, go to IDLE.
- Packet assembly (byte index 0..2):
  - Byte 0 is accepted only if bit3=1. Otherwise discard it, pulse frame_error, keep index at 0 (resync).
  - Bytes 0 and 1 are held in internal registers.
  - On acceptance of byte 2, all packet outputs register together and packet_valid=1 for exactly one clk. Index returns to 0.
  - Outputs hold their values until the next valid packet.
- Latency: packet_valid rises 4 clk after the raw ps2_clk falling edge of byte 2's stop bit (2 sync + 1 edge + 1 output register).
- Timeout:
  - The counter resets on every fall and counts while the FSM is not IDLE or the byte index is not 0.
  - Reaching TIMEOUT_CYCLES: FSM to IDLE, byte index to 0, frame_error pulses once.
  - Timeout never fires while fully idle (IDLE with index 0).
- Simultaneous events: a fall in the same cycle the timeout expires is treated as the edge; the counter resets and there is no timeout.
- Reset mid-frame discards the partial byte and packet, and emits no strobes.

Optional Feature:
- Macro: PS2_CURSOR_EN.
- When defined:
  - cursor_x and cursor_y reset to X_MAX/2 and Y_MAX/2 (319 and 239 by default).
  - On each packet_valid cycle: cursor_x += dx (sign-extended), cursor_y -= dy (screen Y grows downward).
  - Results are saturated to [0, X_MAX] and [0, Y_MAX], computed at 12 bits signed.
  - An axis whose ovf flag is set does not move on that packet.
  - The update is visible in the same cycle packet_valid is high.
- When undefined: cursor_x and cursor_y are tied to 0 and no accumulator logic is present.

Test Plan:
- Frames 0x29, 0x05, 0xFB (correct parity, PS/2 clk ~15 kHz) -> one packet_valid pulse; buttons=3'b001, dx=9'h005, dy=9'h1FB (-5), ovf=0, frame_error never asserted. With PS2_CURSOR_EN: cursor=(324,244).
- Byte 0x05 with bad parity, then a valid 3-byte packet -> frame_error pulse, no packet_valid for the bad sequence, next packet decoded correctly.
- Stream 0x00 (bit3=0), then 0x08, 0x01, 0x02 -> frame_error once, then packet_valid with dx=1, dy=2.
- Send bytes 0x08, 0x10, then hold ps2_clk high for TIMEOUT_CYCLES+10 clk -> single frame_error, no packet_valid, next full packet decodes correctly.
- PS2_CURSOR_EN: 10 packets with byte0=0x18, byte1=0x80 (dx=-128) -> cursor_x saturates at 0; packet with byte0=0x48 -> x_ovf=1, cursor unchanged.
- Assert reset after 5 bits of a frame -> all outputs return to reset values immediately; the following full packet decodes correctly.
